// File: rtl/fpu_pkg.sv
// fpu_pkg: shared bf16 field widths, class encodings, canonical NaN and flag bit positions.
package fpu_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BIAS       = 127;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_e;

  localparam logic [15:0] QNAN = 16'h7FC0;

  // Positions inside the {nv,of,uf,nx} flag vector
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/bf16_rne_round.sv
// bf16_rne_round: round-to-nearest-even of a 7-bit fraction with guard/sticky.
// A carry out of the fraction renormalizes to fraction 0 and bumps the exponent.
module bf16_rne_round
  import fpu_pkg::*;
#(
  parameter int EW = 11
) (
  input  logic [BF16_MAN_W-1:0] i_man,
  input  logic                  i_g,
  input  logic                  i_s,
  input  logic signed [EW-1:0]  i_exp,
  output logic [BF16_MAN_W-1:0] o_man,
  output logic signed [EW-1:0]  o_exp,
  output logic                  o_nx
);

  logic                w_up;
  logic [BF16_MAN_W:0] w_sum;

  // Increment on guard when sticky is set or the lsb is odd (ties to even)
  always_comb begin
    w_up  = i_g & (i_s | i_man[0]);
    w_sum = {1'b0, i_man} + {{BF16_MAN_W{1'b0}}, w_up};
    o_man = w_sum[BF16_MAN_W] ? '0 : w_sum[BF16_MAN_W-1:0];
    o_exp = i_exp + {{(EW-1){1'b0}}, w_sum[BF16_MAN_W]};
    o_nx  = i_g | i_s;
  end

endmodule

// File: rtl/bf16_mul_normround.sv
// bf16_mul_normround: two-stage normalize (S1) / round+pack (S2) back-end of the bf16 multiplier.
// Optional macro BF16_DENORM_EN: tiny results are denormalized and rounded instead of flushed to zero.
module bf16_mul_normround
  import fpu_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [15:0]             in_prod,
  input  logic [1:0]              in_cls,
  input  logic                    in_nv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_res,
  output logic [3:0]              out_flags
);

  // One extra bit so exponent+1 after normalize and rounding can never wrap
  localparam int EI = EXP_W + 1;

  logic                  w_s1_adv, w_s2_adv;
  logic                  r_s1_v, r_s1_sign, r_s1_g, r_s1_s, r_s1_nv;
  logic [BF16_MAN_W-1:0] r_s1_m;
  logic signed [EI-1:0]  r_s1_e;
  cls_e                  r_s1_cls;
  logic                  r_s2_v;
  logic [15:0]           r_res;
  logic [3:0]            r_flags;

  logic [BF16_MAN_W-1:0] w_n_m;
  logic                  w_n_g, w_n_s;
  logic signed [EI-1:0]  w_n_e;

  logic                  w_tiny, w_ovf;
  logic [BF16_MAN_W-1:0] w_ri_m, w_rd_m;
  logic                  w_ri_g, w_ri_s, w_rd_nx;
  logic signed [EI-1:0]  w_ri_e, w_rd_e;
  logic [15:0]           w_res;
  logic [3:0]            w_flags;

  assign w_s2_adv  = !r_s2_v | out_ready;
  assign w_s1_adv  = !r_s1_v | w_s2_adv;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_v;
  assign out_res   = r_res;
  assign out_flags = r_flags;

  // S1 normalize: product is in [1,4); a set bit15 means one extra binade
  always_comb begin
    w_n_m = in_prod[15] ? in_prod[14:8] : in_prod[13:7];
    w_n_g = in_prod[15] ? in_prod[7]    : in_prod[6];
    w_n_s = in_prod[15] ? |in_prod[6:0] : |in_prod[5:0];
    w_n_e = {in_exp[EXP_W-1], in_exp} + {{(EI-1){1'b0}}, in_prod[15]};
  end

  // S1 register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_g    <= 1'b0;
      r_s1_s    <= 1'b0;
      r_s1_nv   <= 1'b0;
      r_s1_m    <= '0;
      r_s1_e    <= '0;
      r_s1_cls  <= CLS_NORMAL;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_sign <= in_sign;
        r_s1_g    <= w_n_g;
        r_s1_s    <= w_n_s;
        r_s1_nv   <= in_nv;
        r_s1_m    <= w_n_m;
        r_s1_e    <= w_n_e;
        r_s1_cls  <= cls_e'(in_cls);
      end
    end
  end

  assign w_tiny = r_s1_e[EI-1] | (r_s1_e == '0);

`ifdef BF16_DENORM_EN
  logic signed [EI-1:0] w_sh;
  logic                 w_dbig;
  logic [8:0]           w_dv, w_dmask;
  logic [7:0]           w_dsh;

  // Right-shift {1,m,G} by 1-e; bits shifted past G feed the sticky
  always_comb begin
    w_sh    = $signed(EI'(1)) - r_s1_e;
    w_dbig  = w_sh > $signed(EI'(8));
    w_dv    = {1'b1, r_s1_m, r_s1_g};
    w_dsh   = 8'(w_dv >> w_sh[3:0]);
    w_dmask = ~(9'h1FF << w_sh[3:0]);
  end
`endif

  // Rounder operands: normalized values, or the denormalized ones for tiny results
  always_comb begin
    w_ri_m = r_s1_m;
    w_ri_g = r_s1_g;
    w_ri_s = r_s1_s;
    w_ri_e = r_s1_e;
`ifdef BF16_DENORM_EN
    if (w_tiny) begin
      w_ri_e = '0;
      if (w_dbig) begin
        w_ri_m = '0;
        w_ri_g = 1'b0;
        w_ri_s = 1'b1;
      end else begin
        w_ri_m = w_dsh[7:1];
        w_ri_g = w_dsh[0];
        w_ri_s = r_s1_s | (|(w_dv & w_dmask));
      end
    end
`endif
  end

  bf16_rne_round #(.EW(EI)) u_round (
    .i_man (w_ri_m),
    .i_g   (w_ri_g),
    .i_s   (w_ri_s),
    .i_exp (w_ri_e),
    .o_man (w_rd_m),
    .o_exp (w_rd_e),
    .o_nx  (w_rd_nx)
  );

  assign w_ovf = !w_rd_e[EI-1] && (w_rd_e[EI-2:0] >= (EI-1)'(255));

  // S2 pack: specials bypass the arithmetic, nv always passes through
  always_comb begin
    w_res            = {r_s1_sign, w_rd_e[7:0], w_rd_m};
    w_flags          = '0;
    w_flags[FLAG_NV] = r_s1_nv;
    case (r_s1_cls)
      CLS_NAN:  w_res = QNAN;
      CLS_INF:  w_res = {r_s1_sign, 8'hFF, 7'h00};
      CLS_ZERO: w_res = {r_s1_sign, 15'h0000};
      default: begin
        if (w_tiny) begin
`ifdef BF16_DENORM_EN
          w_flags[FLAG_UF] = w_rd_nx;
          w_flags[FLAG_NX] = w_rd_nx;
`else
          w_res            = {r_s1_sign, 15'h0000};
          w_flags[FLAG_UF] = 1'b1;
          w_flags[FLAG_NX] = 1'b1;
`endif
        end else if (w_ovf) begin
          w_res            = {r_s1_sign, 8'hFF, 7'h00};
          w_flags[FLAG_OF] = 1'b1;
          w_flags[FLAG_NX] = 1'b1;
        end else begin
          w_flags[FLAG_NX] = w_rd_nx;
        end
      end
    endcase
  end

  // S2 register stage; result held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v  <= 1'b0;
      r_res   <= 16'h0000;
      r_flags <= 4'h0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_bf16_mul_normround.sv
// tb_bf16_mul_normround: directed spec cases plus randomized stream against an arithmetic reference.
module tb_bf16_mul_normround;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [15:0]       in_prod;
  logic [1:0]        in_cls;
  logic              in_nv;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_res;
  logic [3:0]        out_flags;

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct {
    logic        s;
    logic [9:0]  ex;
    logic [15:0] p;
    logic [1:0]  cls;
    logic        nv;
    logic [15:0] res;
    logic [3:0]  flg;
    string       tag;
  } op_t;

  op_t pend[$];
  op_t sb[$];

  bf16_mul_normround dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_prod   (in_prod),
    .in_cls    (in_cls),
    .in_nv     (in_nv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: value = prod * 2^(e-14) with e = in_exp (+1 if prod>=2), rounded to 7 fraction bits.
  function automatic void model(input logic s, input logic [9:0] ex, input logic [15:0] p,
                                input logic [1:0] cls, input logic nv,
                                output logic [15:0] r, output logic [3:0] f);
    int e, k;
    longint pv, q, rem, half;
    bit nx;
    pv = longint'(p);
    e  = int'($signed(ex)) + int'(p[15]);
    k  = p[15] ? 8 : 7;
    r  = 16'h0000;
    f  = {nv, 3'b000};
    if (cls == 2'b11) r = 16'h7FC0;
    else if (cls == 2'b10) r = {s, 8'hFF, 7'h00};
    else if (cls == 2'b01) r = {s, 15'h0000};
    else if (e <= 0) begin
`ifdef BF16_DENORM_EN
      k = k + 1 - e;
      if (k > 40) k = 40;
      q    = pv >> k;
      rem  = pv - (q << k);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      nx = (rem != 0);
      r  = {s, 15'(q)};
      f  = {nv, 1'b0, nx, nx};
`else
      r = {s, 15'h0000};
      f = {nv, 3'b011};
`endif
    end else begin
      q    = pv >> k;
      rem  = pv - (q << k);
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      nx = (rem != 0);
      if (q == 256) begin
        q = 128;
        e++;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 7'h00};
        f = {nv, 3'b101};
      end else begin
        r = {s, 8'(e), 7'(q)};
        f = {nv, 2'b00, nx};
      end
    end
  endfunction

  task automatic add_op(input logic s, input logic [9:0] ex, input logic [15:0] p, input logic [1:0] cls,
                        input logic nv, input logic [15:0] res, input logic [3:0] flg, input string tag);
    op_t o;
    o.s = s; o.ex = ex; o.p = p; o.cls = cls; o.nv = nv; o.res = res; o.flg = flg; o.tag = tag;
    pend.push_back(o);
  endtask

  task automatic add_rand(input string tag);
    logic s, nv;
    logic [9:0] ex;
    logic [15:0] p, r;
    logic [1:0] c;
    logic [3:0] f;
    int sel, ev;
    s   = 1'($urandom_range(0, 1));
    p   = 16'((128 + $urandom_range(0, 127)) * (128 + $urandom_range(0, 127)));
    sel = int'($urandom_range(0, 9));
    if (sel < 5) ev = int'($urandom_range(1, 253));
    else if (sel < 7) ev = int'($urandom_range(0, 12)) - 10;
    else if (sel < 9) ev = int'($urandom_range(248, 258));
    else ev = ($urandom_range(0, 1) == 1) ? 381 : -126;
    ex = 10'(ev);
    c  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    nv = (c != 2'b00) && ($urandom_range(0, 1) == 1);
    model(s, ex, p, c, nv, r, f);
    add_op(s, ex, p, c, nv, r, f, tag);
  endtask

  // One clock: drive at negedge, record accepts and check delivered results before the next posedge
  task automatic cycle(input bit ordy);
    op_t o, e;
    @(negedge clk);
    out_ready = ordy;
    if (pend.size() > 0) begin
      o        = pend[0];
      in_valid = 1'b1;
      in_sign  = o.s;
      in_exp   = o.ex;
      in_prod  = o.p;
      in_cls   = o.cls;
      in_nv    = o.nv;
    end else begin
      in_valid = 1'b0;
      in_prod  = 16'($urandom);
    end
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL extra_output observed=%h expected=none", out_res);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk16({e.tag, "_res"}, out_res, e.res);
        chk16({e.tag, "_flags"}, {12'h000, out_flags}, {12'h000, e.flg});
      end
    end
    if (in_valid && in_ready) sb.push_back(pend.pop_front());
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < budget) begin
      cycle(1'b1);
      n++;
    end
    total++;
    assert (pend.size() == 0 && sb.size() == 0) else begin
      bad++;
      $error("FAIL %s_timeout observed=pend%0d/sb%0d expected=0/0", tag, pend.size(), sb.size());
    end
  endtask

  initial begin
    int n0, n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_prod   = '0;
    in_cls    = 2'b00;
    in_nv     = 1'b0;
    out_ready = 1'b1;
    #3;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk16("rst_out_res", out_res, 16'h0000);
    chk16("rst_out_flags", {12'h000, out_flags}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency: accepted at first posedge, visible after the second
    add_op(1'b0, 10'd127, 16'h9000, 2'b00, 1'b0, 16'h4010, 4'h0, "mul_1p5");
    cycle(1'b1);
    cycle(1'b1);
    chk1("latency_early", out_valid, 1'b0);
    cycle(1'b1);
    chk1("latency_two", out_valid, 1'b1);
    chk1("latency_sb_empty", sb.size() == 0, 1'b1);

    add_op(1'b0, 10'd127, 16'h40C0, 2'b00, 1'b0, 16'h3F82, 4'b0001, "tie_odd");
    add_op(1'b0, 10'd127, 16'h4040, 2'b00, 1'b0, 16'h3F80, 4'b0001, "tie_even");
    add_op(1'b0, 10'd127, 16'h7FC0, 2'b00, 1'b0, 16'h4000, 4'b0001, "round_carry");
    add_op(1'b1, 10'd254, 16'h8000, 2'b00, 1'b0, 16'hFF80, 4'b0101, "overflow");
`ifdef BF16_DENORM_EN
    add_op(1'b0, 10'd0, 16'h4000, 2'b00, 1'b0, 16'h0040, 4'b0000, "underflow");
`else
    add_op(1'b0, 10'd0, 16'h4000, 2'b00, 1'b0, 16'h0000, 4'b0011, "underflow");
`endif
    add_op(1'b0, 10'd5, 16'h4000, 2'b11, 1'b0, 16'h7FC0, 4'b0000, "nan");
    add_op(1'b0, 10'd5, 16'h4000, 2'b10, 1'b1, 16'h7F80, 4'b1000, "inf_nv");
    add_op(1'b1, 10'd5, 16'h4000, 2'b01, 1'b0, 16'h8000, 4'b0000, "zero_neg");
    drain("directed", 60);

    // Backpressure: two ops fill the pipe, then in_ready must drop
    n0 = n_out;
    for (int i = 0; i < 4; i++) add_rand("bp");
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    chk1("bp_in_ready_low", in_ready, 1'b0);
    chk1("bp_out_held", out_valid, 1'b1);
    chk1("bp_two_accepted", sb.size() == 2, 1'b1);
    drain("bp", 40);
    chk1("bp_four_out", (n_out - n0) == 4, 1'b1);

    // Randomized stream with random downstream stalls
    for (int i = 0; i < 300; i++) add_rand("rnd");
    n = 0;
    while ((pend.size() > 0 || sb.size() > 0) && n < 5000) begin
      cycle($urandom_range(0, 3) != 0);
      n++;
    end
    drain("rnd", 100);

    // Mid-stream reset discards everything immediately
    for (int i = 0; i < 4; i++) add_rand("rstm");
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    chk1("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk16("midrst_out_res", out_res, 16'h0000);
    pend.delete();
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    add_op(1'b0, 10'd127, 16'h9000, 2'b00, 1'b0, 16'h4010, 4'h0, "post_rst");
    drain("post_rst", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
